// File: rtl/axi4_burst_write_gen_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst generator and an AXI slave.
interface axi4_burst_write_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi4_burst_write_gen.sv
// Single-outstanding AXI4 INCR write-burst master: one command in, one burst out, one response back.
// Illegal commands (oversized beat, misaligned, 4 KB crossing) are rejected locally without bus traffic.
module axi4_burst_write_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_aresetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [7:0]             cmd_len,
  input  logic [2:0]             cmd_size,
  input  logic [1:0]             cmd_mode,
  input  logic [DATA_W-1:0]      cmd_seed,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_code,
  output logic                   busy,
  output logic [CNT_W-1:0]       burst_cnt,
  axi4_burst_write_gen_if.master m_axi
);
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ADDR, S_DATA, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [7:0]          beat_q, beat_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                wlast_q, wlast_d;
  logic                bready_q, bready_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2:0]          rsp_code_q, rsp_code_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [15:0]         end_off_s;
  logic [7:0]          align_mask_s;
  logic                local_err_s;

  function automatic logic [DATA_W-1:0] beat_data(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] seed,
                                                  input logic [7:0] idx);
    logic [DATA_W-1:0] r;
    int                sh;
    sh = int'(idx) % DATA_W;
    case (mode)
      2'd0:    r = seed;
      2'd1:    r = seed + DATA_W'(idx);
      2'd2:    r = (seed << sh) | (seed >> (DATA_W - sh));
      2'd3:    r = idx[0] ? ~seed : seed;
      default: r = seed;
    endcase
    return r;
  endfunction

  // Legality of the latched command; end offset is kept wide enough that it never wraps.
  always_comb begin
    end_off_s    = {4'd0, addr_q[11:0]} + (({8'd0, len_q} + 16'd1) << size_q);
    align_mask_s = (8'd1 << size_q) - 8'd1;
    local_err_s  = (size_q > 3'(MAX_SIZE)) ||
                   ((addr_q[7:0] & align_mask_s) != 8'd0) ||
                   (end_off_s > 16'd4096);
  end

  // Burst sequencer: next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    beat_d      = beat_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          len_d       = cmd_len;
          size_d      = cmd_size;
          mode_d      = cmd_mode;
          seed_d      = cmd_seed;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (local_err_s) begin
          rsp_valid_d = 1'b1;
          rsp_code_d  = 3'b100;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          awvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wdata_d   = beat_data(mode_q, seed_q, 8'd0);
          wlast_d   = (len_q == 8'd0);
          beat_d    = 8'd0;
          state_d   = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (m_axi.wready && wlast_q) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
          bready_d = 1'b1;
          state_d  = S_RESP;
        end else if (m_axi.wready) begin
          beat_d  = beat_q + 8'd1;
          wdata_d = beat_data(mode_q, seed_q, beat_q + 8'd1);
          wlast_d = ((beat_q + 8'd1) == len_q);
        end else begin
          state_d = S_DATA;
        end
      end
      S_RESP: begin
        if (m_axi.bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = {1'b0, m_axi.bresp};
          burst_cnt_d = (m_axi.bresp == 2'b00) ? burst_cnt_q + CNT_W'(1) : burst_cnt_q;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      mode_q      <= 2'd0;
      seed_q      <= '0;
      beat_q      <= 8'd0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 3'd0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      mode_q      <= mode_d;
      seed_q      <= seed_d;
      beat_q      <= beat_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_code      = rsp_code_q;
  assign busy          = busy_q;
  assign burst_cnt     = burst_cnt_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = size_q;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b010;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
endmodule

// File: tb/tb_axi4_burst_write_gen.sv
// Directed bench for axi4_burst_write_gen: table of commands against a reactive slave, plus a mid-burst reset.
module tb_axi4_burst_write_gen;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [31:0]  cmd_addr = 32'd0;
  logic [7:0]   cmd_len = 8'd0;
  logic [2:0]   cmd_size = 3'd0;
  logic [1:0]   cmd_mode = 2'd0;
  logic [127:0] cmd_seed = 128'd0;
  logic         rsp_valid;
  logic [2:0]   rsp_code;
  logic         busy;
  logic [31:0]  burst_cnt;

  axi4_burst_write_gen_if #(.ADDR_W(32), .DATA_W(128)) axi ();

  axi4_burst_write_gen #(.ADDR_W(32), .DATA_W(128), .CNT_W(32)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_mode(cmd_mode), .cmd_seed(cmd_seed),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .busy(busy), .burst_cnt(burst_cnt),
    .m_axi(axi.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  addr;
    logic [7:0]   len;
    logic [2:0]   size;
    logic [1:0]   mode;
    logic [127:0] seed;
    bit           tog;
    logic [1:0]   bresp;
    logic [2:0]   code;
  } vec_t;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  bit tog_en = 1'b0;
  logic [1:0] bresp_sel = 2'b00;
  bit b_owed = 1'b0;
  int aw_cnt = 0;
  int aw_seen = 0;
  logic [31:0] cap_addr;
  logic [7:0]  cap_len;
  logic [2:0]  cap_size;
  logic [8:0]  cap_fixed;
  logic [15:0] cap_strb;
  logic [127:0] wq[$];
  logic         lastq[$];
  vec_t vt[12];

  initial begin
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [1:0] mode, input logic [127:0] seed, input int i);
    logic [127:0] r;
    r = seed;
    case (mode)
      2'd1: r = seed + 128'(i);
      2'd2: for (int k = 0; k < (i % 128); k++) r = {r[126:0], r[127]};
      2'd3: if ((i % 2) == 1) r = ~seed;
      default: r = seed;
    endcase
    return r;
  endfunction

  // Slave and monitor: inputs change on the falling edge, handshakes are judged on what the next rising edge sees.
  always @(negedge clk) begin
    if (!rst_n) begin
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
      b_owed      = 1'b0;
    end else begin
      axi.awready = 1'b1;
      axi.wready  = tog_en ? ~axi.wready : 1'b1;
      axi.bvalid  = b_owed;
      axi.bresp   = bresp_sel;
      if (axi.awvalid) aw_seen++;
      if (axi.awvalid && axi.awready) begin
        aw_cnt++;
        cap_addr  = axi.awaddr;
        cap_len   = axi.awlen;
        cap_size  = axi.awsize;
        cap_fixed = {axi.awburst, axi.awcache, axi.awprot};
      end
      if (axi.wvalid && axi.wready) begin
        wq.push_back(axi.wdata);
        lastq.push_back(axi.wlast);
        cap_strb = axi.wstrb;
        if (axi.wlast) b_owed = 1'b1;
      end
      if (axi.bvalid && axi.bready) b_owed = 1'b0;
    end
  end

  task automatic issue(input vec_t v);
    wq.delete();
    lastq.delete();
    aw_cnt = 0;
    aw_seen = 0;
    tog_en = v.tog;
    bresp_sel = v.bresp;
    @(negedge clk);
    #1;
    cmd_addr = v.addr; cmd_len = v.len; cmd_size = v.size;
    cmd_mode = v.mode; cmd_seed = v.seed; cmd_valid = 1'b1;
    @(negedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_and_check(input vec_t v, input int idx);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    issue(v);
    check({tag, "_busy"}, busy, 1'b1);
    cyc = 1;
    while (!rsp_valid && cyc < 1000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
    check({tag, "_code"}, rsp_code, v.code);
    if (v.code == 3'b000) exp_cnt++;
    check({tag, "_burst_cnt"}, burst_cnt, exp_cnt);
    if (v.code[2]) begin
      check({tag, "_no_aw"}, aw_seen, 0);
      check({tag, "_no_w"}, wq.size(), 0);
      check({tag, "_err_cycles"}, cyc, 2);
    end else begin
      check({tag, "_aw_once"}, aw_cnt, 1);
      check({tag, "_awaddr"}, cap_addr, v.addr);
      check({tag, "_awlen"}, cap_len, v.len);
      check({tag, "_awsize"}, cap_size, v.size);
      check({tag, "_aw_fixed"}, cap_fixed, 9'b01_0011_010);
      check({tag, "_wstrb"}, cap_strb, 16'hFFFF);
      check({tag, "_beats"}, wq.size(), int'(v.len) + 1);
      for (int i = 0; i < wq.size(); i++) begin
        check($sformatf("%s_wdata%0d", tag, i), wq[i], model(v.mode, v.seed, i));
        check($sformatf("%s_wlast%0d", tag, i), lastq[i], (i == int'(v.len)));
      end
      if (!v.tog) check({tag, "_cycles"}, cyc, int'(v.len) + 5);
    end
    @(negedge clk);
    #1;
    check({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
    check({tag, "_ready_after"}, cmd_ready, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    vt[0]  = '{32'hA001_0000, 8'd15,  3'd4, 2'd0, {128{1'b1}},       1'b0, 2'b00, 3'b000};
    vt[1]  = '{32'hA001_0100, 8'd7,   3'd4, 2'd1, 128'd0,            1'b1, 2'b00, 3'b000};
    vt[2]  = '{32'hA001_0F80, 8'd15,  3'd4, 2'd0, 128'd1,            1'b0, 2'b00, 3'b100};
    vt[3]  = '{32'hA001_0000, 8'd0,   3'd5, 2'd0, 128'd5,            1'b0, 2'b00, 3'b100};
    vt[4]  = '{32'hA001_0004, 8'd0,   3'd4, 2'd0, 128'd5,            1'b0, 2'b00, 3'b100};
    vt[5]  = '{32'hA001_0200, 8'd3,   3'd4, 2'd0, 128'h55,           1'b0, 2'b10, 3'b010};
    vt[6]  = '{32'hA001_0300, 8'd3,   3'd4, 2'd3, 128'h0F0F,         1'b0, 2'b00, 3'b000};
    vt[7]  = '{32'hA001_0F00, 8'd15,  3'd4, 2'd2, 128'd1,            1'b0, 2'b00, 3'b000};
    vt[8]  = '{32'hA001_0400, 8'd0,   3'd4, 2'd1, 128'hFF,           1'b0, 2'b00, 3'b000};
    vt[9]  = '{32'hA001_0002, 8'd1,   3'd2, 2'd0, 128'd3,            1'b0, 2'b00, 3'b100};
    vt[10] = '{32'hA001_0000, 8'd255, 3'd0, 2'd2, {1'b1, 126'd0, 1'b1}, 1'b1, 2'b00, 3'b000};
    vt[11] = '{32'hA001_0012, 8'd3,   3'd1, 2'd1, 128'd5,            1'b0, 2'b11, 3'b011};

    repeat (3) @(negedge clk);
    #1;
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid", axi.wvalid, 1'b0);
    check("rst_bready", axi.bready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_burst_cnt", burst_cnt, 32'd0);
    check("rst_rsp_code", rsp_code, 3'd0);
    check("rst_awaddr", axi.awaddr, 32'd0);
    check("rst_wdata", axi.wdata, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("idle_cmd_ready", cmd_ready, 1'b1);

    for (int n = 0; n < 12; n++) run_and_check(vt[n], n);

    // Mid-burst reset: 16-beat burst cut during its fifth beat.
    begin
      int guard;
      issue(vt[0]);
      guard = 0;
      while (wq.size() < 5 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check("mid_reach_beat5", guard < 200, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_awvalid", axi.awvalid, 1'b0);
      check("mid_wvalid", axi.wvalid, 1'b0);
      check("mid_bready", axi.bready, 1'b0);
      check("mid_busy", busy, 1'b0);
      check("mid_burst_cnt", burst_cnt, 32'd0);
      check("mid_rsp_valid", rsp_valid, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      exp_cnt = 0;
      guard = 0;
      repeat (3) begin
        @(negedge clk);
        #1;
        if (rsp_valid) guard++;
      end
      check("mid_no_rsp", guard, 0);
      check("mid_ready_again", cmd_ready, 1'b1);
      run_and_check(vt[0], 100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
